// File: rtl/adc_fifo_pkg.sv
// ADC sample FIFO shared package.
// Width helpers and default parameter values.
package adc_fifo_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_AE_THRESH = 4;
  localparam int DEF_DROP_W    = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
// Read-before-write on an address collision.
module fifo_sdp_ram
  import adc_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [ptr_w(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    re_i,
  input  logic [ptr_w(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample buffer: level/threshold status, sticky
// error flags, saturating drop counter, flush.
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int ZERO_IDLE = 1,
  parameter int DROP_W    = DEF_DROP_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       dato_in_i,
  input  logic                    wr_en_i,
  input  logic                    ready_i,
  input  logic                    rd_en_i,
  output logic [DATA_W-1:0]       dato_o,
  output logic                    dato_valid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic [DROP_W-1:0]       drop_cnt_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [LW-1:0]     cnt_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] ram_q;
  logic              wr_req;
  logic              wr_acc;
  logic              rd_acc;

  assign full_o         = (cnt_q == FULL_L);
  assign empty_o        = (cnt_q == '0);
  assign almost_full_o  = (cnt_q >= AF_L);
  assign almost_empty_o = (cnt_q <= AE_L);
  assign level_o        = cnt_q;

  assign wr_req = wr_en_i & ready_i;
  assign rd_acc = rd_en_i & ~empty_o & ~flush_i;
  assign wr_acc = wr_req & (~full_o | rd_acc) & ~flush_i;

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc & rst_ni),
    .waddr_i (wptr_q),
    .wdata_i (dato_in_i),
    .re_i    (rd_acc & rst_ni),
    .raddr_i (rptr_q),
    .rdata_o (ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      dato_valid_o <= 1'b0;
      dato_o       <= '0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
      drop_cnt_o   <= '0;
    end else if (flush_i) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      rd_vld_q     <= 1'b0;
      dato_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
      underflow_o  <= 1'b0;
      drop_cnt_o   <= '0;
      if (ZERO_IDLE != 0) dato_o <= '0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + 1'b1;
      if (rd_acc) rptr_q <= rptr_q + 1'b1;
      unique case (1'b1)
        (wr_acc & ~rd_acc): cnt_q <= cnt_q + 1'b1;
        (rd_acc & ~wr_acc): cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      if (wr_req & ~wr_acc) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != DROP_MAX)
          drop_cnt_o <= drop_cnt_o + 1'b1;
      end
      if (rd_en_i & empty_o) underflow_o <= 1'b1;
      // RAM register, then output register
      rd_vld_q     <= rd_acc;
      dato_valid_o <= rd_vld_q;
      if (rd_vld_q)
        dato_o <= ram_q;
      else if (ZERO_IDLE != 0)
        dato_o <= '0;
    end
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo, both idle modes.
// Queue-based reference model, randomized traffic.
module tb_adc_sample_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;
  localparam int DMAX  = 7;

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] din = '0;
  logic        wr_en = 1'b0;
  logic        ready = 1'b0;
  logic        rd_en = 1'b0;

  logic [15:0] z_dat, h_dat;
  logic        z_vld, h_vld;
  logic        z_full, h_full, z_empty, h_empty;
  logic        z_af, h_af, z_ae, h_ae;
  logic [3:0]  z_lvl, h_lvl;
  logic        z_ovf, h_ovf, z_unf, h_unf;
  logic [2:0]  z_drop, h_drop;

  logic [15:0] mq[$];
  exp_t        exp_q[$];
  bit          m_ovf, m_unf;
  int          m_drop;
  logic [15:0] last_val;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_fifo #(
    .DATA_W(16), .DEPTH(DEPTH), .AF_THRESH(AF),
    .AE_THRESH(AE), .ZERO_IDLE(1), .DROP_W(3)
  ) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .dato_in_i(din), .wr_en_i(wr_en), .ready_i(ready),
    .rd_en_i(rd_en), .dato_o(z_dat), .dato_valid_o(z_vld),
    .full_o(z_full), .empty_o(z_empty),
    .almost_full_o(z_af), .almost_empty_o(z_ae),
    .level_o(z_lvl), .overflow_o(z_ovf),
    .underflow_o(z_unf), .drop_cnt_o(z_drop)
  );

  adc_sample_fifo #(
    .DATA_W(16), .DEPTH(DEPTH), .AF_THRESH(AF),
    .AE_THRESH(AE), .ZERO_IDLE(0), .DROP_W(3)
  ) dut_h (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .dato_in_i(din), .wr_en_i(wr_en), .ready_i(ready),
    .rd_en_i(rd_en), .dato_o(h_dat), .dato_valid_o(h_vld),
    .full_o(h_full), .empty_o(h_empty),
    .almost_full_o(h_af), .almost_empty_o(h_ae),
    .level_o(h_lvl), .overflow_o(h_ovf),
    .underflow_o(h_unf), .drop_cnt_o(h_drop)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h",
               n, cyc, a, e);
    end
  endtask

  task automatic chk_status(input string t,
                            input logic [3:0] lvl,
                            input logic f, input logic em,
                            input logic af, input logic ae,
                            input logic ov, input logic un,
                            input logic [2:0] dr);
    int sz;
    sz = mq.size();
    chk({t, "_level"}, 32'(lvl), 32'(sz));
    chk({t, "_full"}, 32'(f), 32'(sz == DEPTH));
    chk({t, "_empty"}, 32'(em), 32'(sz == 0));
    chk({t, "_afull"}, 32'(af), 32'(sz >= AF));
    chk({t, "_aempty"}, 32'(ae), 32'(sz <= AE));
    chk({t, "_ovf"}, 32'(ov), 32'(m_ovf));
    chk({t, "_unf"}, 32'(un), 32'(m_unf));
    chk({t, "_drop"}, 32'(dr), 32'(m_drop));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk_status("z", z_lvl, z_full, z_empty, z_af, z_ae,
                 z_ovf, z_unf, z_drop);
      chk_status("h", h_lvl, h_full, h_empty, h_af, h_ae,
                 h_ovf, h_unf, h_drop);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("z_valid", 32'(z_vld), 32'd1);
        chk("h_valid", 32'(h_vld), 32'd1);
        chk("z_data", 32'(z_dat), 32'(e.d));
        chk("h_data", 32'(h_dat), 32'(e.d));
        last_val = e.d;
      end else begin
        chk("z_valid_idle", 32'(z_vld), 32'd0);
        chk("h_valid_idle", 32'(h_vld), 32'd0);
        chk("z_data_zero", 32'(z_dat), 32'd0);
        chk("h_data_hold", 32'(h_dat), 32'(last_val));
      end
    end
  end

  // Inputs land #1 after negedge; model then holds the
  // state expected after the coming rising edge.
  task automatic step(input bit rst, input bit fl,
                      input bit wr, input bit rdy,
                      input bit rd, input logic [15:0] d);
    bit rd_ok, wr_req, wr_ok;
    @(negedge clk);
    #1;
    rst_n = rst; flush = fl; wr_en = wr;
    ready = rdy; rd_en = rd; din = d;
    if (!rst || fl) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_drop = 0;
      if (!rst) last_val = '0;
    end else begin
      rd_ok  = rd && (mq.size() > 0);
      wr_req = wr && rdy;
      wr_ok  = wr_req && (mq.size() < DEPTH || rd_ok);
      if (rd && mq.size() == 0) m_unf = 1;
      if (wr_req && !wr_ok) begin
        m_ovf = 1;
        if (m_drop < DMAX) m_drop++;
      end
      if (rd_ok) begin
        exp_t e;
        e.d = mq.pop_front();
        e.due = cyc + 2;
        exp_q.push_back(e);
      end
      if (wr_ok) mq.push_back(d);
    end
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] d);
    step(1, 0, 1, 1, 0, d);
  endtask

  task automatic rd(input int n);
    repeat (n) step(1, 0, 0, 0, 1, 16'h0);
  endtask

  task automatic fill_ovf_to5();
    for (int i = 0; i < 10; i++) wr(16'h4000 + 16'(i));
    rd(3);
  endtask

  initial begin
    // reset and basic flow
    step(0, 0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 3; i++) wr(16'(i));
    rd(3);
    idle(3);
    // ready qualification
    repeat (5) step(1, 0, 1, 0, 0, 16'h1111);
    wr(16'hABCD);
    rd(1);
    idle(3);
    // overflow, then full with read+write
    for (int i = 0; i < 10; i++) wr(16'h0100 + 16'(i));
    step(1, 0, 1, 1, 1, 16'h2000);
    rd(9);
    idle(3);
    // underflow
    rd(1);
    idle(3);
    // flush with a write pending
    fill_ovf_to5();
    step(1, 1, 1, 1, 0, 16'h3333);
    idle(3);
    // reset with a write pending
    fill_ovf_to5();
    step(0, 0, 1, 1, 0, 16'h5555);
    idle(3);
    // drop counter saturation
    for (int i = 0; i < 20; i++) wr(16'h6000 + 16'(i));
    step(1, 0, 1, 1, 1, 16'h7777);
    rd(2);
    step(1, 1, 0, 0, 1, 16'h0);
    idle(2);
    // randomized traffic in write/read-biased phases
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 120; i++) begin
        bit r, f, w, y, q;
        r = ($urandom_range(0, 99) != 0);
        f = ($urandom_range(0, 59) == 0);
        w = ($urandom_range(0, 9) < ((p % 2) ? 3 : 8));
        y = ($urandom_range(0, 9) < 8);
        q = ($urandom_range(0, 9) < ((p % 2) ? 8 : 3));
        step(r, f, w, y, q, 16'($urandom));
      end
    end
    rd(DEPTH + 2);
    idle(4);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

Parametrised, single-clock sample buffer between the ADC capture front end and the downstream reader/packer. It replaces the fixed 16x1024 vendor-FIFO wrapper with inferred storage and configurable width and depth. It adds level reporting, almost-full/almost-empty thresholds, sticky overflow/underflow flags with a saturating drop counter, a synchronous flush, and a selectable output-idle mode. Writes are qualified by the ADC `ready_i` strobe, as in the previous generation.

## Interface
Parameters:
- `DATA_W`, 16: sample width in bits.
- `DEPTH`, 1024: number of entries; power of two, ≥ 4.
- `AF_THRESH`, DEPTH-4: `almost_full_o` asserts when level ≥ AF_THRESH.
- `AE_THRESH`, 4: `almost_empty_o` asserts when level ≤ AE_THRESH.
- `ZERO_IDLE`, 1: 1 drives `dato_o` to 0 in any cycle without a valid read; 0 holds the last read value.
- `DROP_W`, 16: width of the drop counter.

Ports:
- `clk_i` in 1: the single clock; all logic on the rising edge.
- `rst_ni` in 1: synchronous, active-low reset.
- `flush_i` in 1: synchronous flush; empties the FIFO and clears flags and counter.
- `dato_in_i` in DATA_W: ADC sample.
- `wr_en_i` in 1: capture enable.
- `ready_i` in 1: ADC sample-ready strobe. A write is requested when `wr_en_i & ready_i`.
- `rd_en_i` in 1: read request.
- `dato_o` out DATA_W: read data, registered.
- `dato_valid_o` out 1: `dato_o` holds a valid read this cycle.
- `full_o`, `empty_o` out 1: storage status.
- `almost_full_o`, `almost_empty_o` out 1: threshold status.
- `level_o` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow_o`, `underflow_o` out 1: sticky error flags.
- `drop_cnt_o` out DROP_W: count of dropped writes, saturating.

## Operation
- Storage: DEPTH x DATA_W array. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally. Occupancy is kept in a count register of $clog2(DEPTH)+1 bits.
- `full_o` = (count == DEPTH). `empty_o` = (count == 0). `level_o` = count. The almost flags are compares on count. All status outputs derive from registers and carry no combinational path from inputs.
- Write accepted when `wr_en_i & ready_i` and (`!full_o` or a read is accepted in the same cycle).
- Read accepted when `rd_en_i & !empty_o`.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. This holds at full as well.
- Write request while full with no accepted read:
  - data is dropped, nothing in storage changes;
  - `overflow_o` sets;
  - `drop_cnt_o` increments, saturating at 2^DROP_W-1.
- Read request while empty: ignored, `underflow_o` sets, `dato_valid_o` stays 0. A write in the same cycle is still accepted, with no bypass to the read port.
- Priority, highest first: reset, flush, normal operation. Flush zeroes pointers, count, flags and the drop counter, and forces `dato_valid_o`=0. Any read or write in the flush cycle is discarded.
- Reset mid-operation discards all contents. Storage array contents are don't-care after reset; only the pointers define validity.

## Timing
- Reset values: `dato_o`=0, `dato_valid_o`=0, `empty_o`=1, `almost_empty_o`=1, `full_o`=0, `almost_full_o`=0, `level_o`=0, `overflow_o`=0, `underflow_o`=0, `drop_cnt_o`=0.
- Read latency: 1 cycle. For a read accepted at edge N, `dato_o` and `dato_valid_o`=1 are presented after edge N+1 for one cycle.
- `dato_o` in cycles without a valid read:
  - `ZERO_IDLE`=1: `dato_o`=0.
  - `ZERO_IDLE`=0: `dato_o` holds its value.
- Write-to-status: for a write accepted at edge N, `level_o`, `empty_o` and the almost flags update after edge N.
- Write-to-readable: the earliest accepted read of that word is at edge N+1, with data out after edge N+2.
- Back-to-back reads sustain 1 word per clock.

## Structure
- Package `adc_fifo_pkg`:
  - `clog2`-derived width helpers: `ptr_w(DEPTH)`, `lvl_w(DEPTH)`;
  - default parameter constants.
- Sub-module `fifo_sdp_ram`: simple dual-port inferred RAM with one write port and one registered read port, parameterised on DATA_W and DEPTH.
- All pointers, counters, flags and output muxing live in the top.

## Test plan
All scenarios use DATA_W=16, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- **Reset and basic flow.** Hold `rst_ni`=0 for 2 cycles, then write 0x0001..0x0003 with `wr_en_i`=`ready_i`=1 and read 3 times. Required: reset values as listed; reads return 1, 2, 3 each one cycle after the request; `level_o` goes 3 → 0; `empty_o`=1 at the end.
- **ready_i qualification.** Set `wr_en_i`=1 and `ready_i`=0 for 5 cycles. Required: `level_o` stays 0. Then pulse `ready_i` for 1 cycle with data 0xABCD. Required: `level_o`=1 and the next read returns 0xABCD.
- **Overflow.** Write 10 words with no reads. Required: `full_o`=1 after the 8th; `overflow_o`=1; `drop_cnt_o`=2; reads return the first 8 words in order.
- **Full with simultaneous read and write.** At level 8, assert `rd_en_i` and a write together. Required: `level_o` stays 8 and `drop_cnt_o` is unchanged.
- **Underflow and idle mode.** Read while empty. Required: `underflow_o`=1 and `dato_valid_o`=0. With `ZERO_IDLE`=1, `dato_o`=0 in idle cycles; with `ZERO_IDLE`=0, `dato_o` holds the last value.
- **Flush and reset mid-stream.** At level 5 with `overflow_o`=1, pulse `flush_i` while a write is requested. Required: next cycle `level_o`=0, all flags 0, the write is discarded. Repeat the scenario with `rst_ni`=0; required result is the same.
